// File: rtl/serdes_pkg.sv
// Shared types and helpers for the serial link blocks (serializer / deserializer).
package serdes_pkg;

  typedef enum logic {
    S_SHIFT = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  // Width of a counter that indexes bit positions 0..len-1 (at least one bit).
  function automatic int cnt_width(input int len);
    return (len <= 2) ? 1 : $clog2(len);
  endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// Serial-in parallel-out shift register. next_o shows the value the register
// takes on a shift, so the owner can capture a word that completes this edge.
module sipo_shift_reg #(
  parameter int LENGTH    = 24,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              shift_i,
  input  logic              din_i,
  output logic [LENGTH-1:0] word_o,
  output logic [LENGTH-1:0] next_o
);

  logic [LENGTH-1:0] sr_q;

  generate
    if (MSB_FIRST) begin : g_msb
      // First bit received ends up in the top position after LENGTH shifts.
      assign next_o = {sr_q[LENGTH-2:0], din_i};
    end else begin : g_lsb
      // First bit received ends up in bit 0 after LENGTH shifts.
      assign next_o = {din_i, sr_q[LENGTH-1:1]};
    end
  endgenerate

  // Shift storage; only moves when a bit is accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q <= '0;
    end else if (shift_i) begin
      sr_q <= next_o;
    end
  end

  assign word_o = sr_q;

endmodule

// File: rtl/deserializer_fsm.sv
// Serial-to-parallel receiver with one-word holding stage. The shift register
// doubles as the holding stage in S_FULL, so a second word can complete while
// the first is still waiting on the parallel output.
module deserializer_fsm
  import serdes_pkg::*;
#(
  parameter int LENGTH    = 24,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_din,
  input  logic              i_din_valid,
  output logic              o_ready,
  output logic [LENGTH-1:0] ov_dout,
  output logic              o_dout_valid,
  input  logic              i_ready
);

  localparam int CNT_W = cnt_width(LENGTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LENGTH - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LENGTH-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;

  logic              accept;
  logic              consume;
  logic              shift_en;
  logic [LENGTH-1:0] sr_word;
  logic [LENGTH-1:0] sr_next;

  sipo_shift_reg #(
    .LENGTH   (LENGTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_sr (
    .clk_i  (i_clk),
    .rst_ni (i_rst_n),
    .shift_i(shift_en),
    .din_i  (i_din),
    .word_o (sr_word),
    .next_o (sr_next)
  );

  assign o_ready      = i_en && (state_q == S_SHIFT);
  assign accept       = i_din_valid && o_ready;
  assign consume      = dout_valid_q && i_ready;
  assign ov_dout      = dout_q;
  assign o_dout_valid = dout_valid_q;

  // State, bit counter and output register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_SHIFT;
      cnt_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  // Next-state: accept bits, hand completed words to the output or hold them.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    shift_en     = 1'b0;

    // Consumption is never gated by i_en; a load below may re-assert valid.
    if (consume) begin
      dout_valid_d = 1'b0;
    end

    case (state_q)
      S_SHIFT: begin
        if (accept) begin
          shift_en = 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (!dout_valid_q || consume) begin
              dout_d       = sr_next;
              dout_valid_d = 1'b1;
            end else begin
              state_d = S_FULL;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_FULL: begin
        if (consume) begin
          dout_d       = sr_word;
          dout_valid_d = 1'b1;
          cnt_d        = '0;
          state_d      = S_SHIFT;
        end
      end
      default: state_d = S_SHIFT;
    endcase
  end

endmodule

// File: tb/tb_deserializer_fsm.sv
// Bench for deserializer_fsm: an LSB-first and an MSB-first instance share the
// same stimulus and are checked each cycle against a word-level model.
module tb_deserializer_fsm;

  localparam int L = 24;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         din = 1'b0;
  logic         din_valid = 1'b0;
  logic         i_ready = 1'b0;
  logic         ready_l, ready_m, valid_l, valid_m;
  logic [L-1:0] dout_l, dout_m;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  deserializer_fsm #(.LENGTH(L), .MSB_FIRST(1'b0)) u_lsb (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_din(din), .i_din_valid(din_valid),
    .o_ready(ready_l), .ov_dout(dout_l), .o_dout_valid(valid_l), .i_ready(i_ready)
  );

  deserializer_fsm #(.LENGTH(L), .MSB_FIRST(1'b1)) u_msb (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_din(din), .i_din_valid(din_valid),
    .o_ready(ready_m), .ov_dout(dout_m), .o_dout_valid(valid_m), .i_ready(i_ready)
  );

  task automatic check(input string name, input logic [L-1:0] got, input logic [L-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- word-level model ----------------
  // Output slot plus one held word; bits collected in arrival order.
  logic [L-1:0] m_out_l = '0, m_out_m = '0, m_held_l = '0, m_held_m = '0;
  bit           m_valid = 0, m_held = 0;
  int           m_n = 0;
  bit           m_bits[L];

  initial forever begin
    bit acc, cons;
    logic [L-1:0] wl, wm;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_out_l = '0; m_out_m = '0; m_valid = 0; m_held = 0; m_n = 0;
    end else begin
      acc  = en && din_valid && !m_held;
      cons = m_valid && i_ready;
      if (cons) m_valid = 0;
      if (m_held) begin
        if (cons) begin
          m_out_l = m_held_l; m_out_m = m_held_m; m_valid = 1; m_held = 0;
        end
      end else if (acc) begin
        m_bits[m_n] = din;
        m_n++;
        if (m_n == L) begin
          m_n = 0;
          wl = '0; wm = '0;
          for (int k = 0; k < L; k++) begin
            wl[k]     = m_bits[k];
            wm[L-1-k] = m_bits[k];
          end
          if (!m_valid) begin
            m_out_l = wl; m_out_m = wm; m_valid = 1;
          end else begin
            m_held_l = wl; m_held_m = wm; m_held = 1;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    check("ready_l", ready_l, (en && !m_held) ? 1 : 0);
    check("ready_m", ready_m, (en && !m_held) ? 1 : 0);
    check("valid_l", valid_l, m_valid);
    check("valid_m", valid_m, m_valid);
    check("dout_l",  dout_l,  m_out_l);
    check("dout_m",  dout_m,  m_out_m);
  end

  // Words actually taken by the consumer, captured from the DUT.
  logic [L-1:0] last_l = '0, last_m = '0;
  logic [L-1:0] got_q[$];
  logic [L-1:0] sent_q[$];
  bit           collect = 0;
  bit           rand_ready = 0;

  initial forever begin
    @(posedge clk);
    if (rst_n && valid_l && i_ready) begin
      last_l = dout_l;
      last_m = dout_m;
      if (collect) got_q.push_back(dout_l);
    end
  end

  initial forever begin
    @(negedge clk);
    #1;
    if (rand_ready) i_ready = ($urandom_range(0, 2) != 0);
  end

  // Offer one bit until accepted (bounded).
  task automatic send_bit(input logic b);
    bit done = 0;
    for (int t = 0; t < 60 && !done; t++) begin
      @(negedge clk); #1;
      din = b; din_valid = 1'b1;
      #2;
      done = ready_l;
      @(posedge clk);
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL send_bit_timeout got=0 exp=1 at %0t", $time);
    end
    @(negedge clk); #1;
    din_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1; din_valid = 1'b0;
    end
  endtask

  task automatic send_word(input logic [L-1:0] w, input bit msb, input bit gaps);
    for (int k = 0; k < L; k++) begin
      if (gaps && (k % 3 == 2)) idle(1);
      if (gaps && k == 12) begin
        // Enable low with valid asserted: nothing may be taken.
        @(negedge clk); #1; en = 1'b0; din = 1'b1; din_valid = 1'b1;
        repeat (5) @(negedge clk);
        #1; en = 1'b1; din_valid = 1'b0;
      end
      send_bit(msb ? w[L-1-k] : w[k]);
    end
  endtask

  initial begin
    logic [L-1:0] w;
    logic [L-1:0] vec[3];
    vec[0] = 24'hFF00FF; vec[1] = 24'h00FF00; vec[2] = 24'hAF5EB9;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_dout", dout_l, 24'h0);
    check("reset_valid", valid_l, 1'b0);
    check("reset_ready_en0", ready_l, 1'b0);
    #1; rst_n = 1'b1; en = 1'b1; i_ready = 1'b1;

    // Contiguous words, consumer always ready.
    for (int i = 0; i < 3; i++) begin
      send_word(vec[i], 0, 0);
      idle(3);
      check("word_lsb", last_l, vec[i]);
      $display("word %0d: sent=%h got=%h", i, vec[i], last_l);
    end

    // Backpressure: two words fill output and holding stage.
    i_ready = 1'b0;
    send_word(24'h123456, 0, 0);
    send_word(24'hABCDEF, 0, 0);
    @(negedge clk);
    check("bp_ready_low", ready_l, 1'b0);
    check("bp_hold_first", dout_l, 24'h123456);
    #1; din = 1'b1; din_valid = 1'b1;          // ignored while o_ready=0
    @(negedge clk); #1; din_valid = 1'b0; i_ready = 1'b1;
    @(negedge clk); #1; i_ready = 1'b0;
    check("bp_second_word", dout_l, 24'hABCDEF);
    check("bp_ready_back", ready_l, 1'b1);
    $display("backpressure: dout=%h ready=%0d", dout_l, ready_l);
    @(negedge clk); #1; i_ready = 1'b1;
    idle(2);

    // Valid gaps and enable low mid-word.
    send_word(24'hC3A501, 0, 1);
    idle(3);
    check("gaps_word", last_l, 24'hC3A501);
    $display("gaps: got=%h", last_l);

    // Asynchronous reset in the middle of a word.
    for (int k = 0; k < 10; k++) send_bit(1'b1);
    @(negedge clk); #2; rst_n = 1'b0; #1;
    check("rst_dout", dout_l, 24'h0);
    check("rst_valid", valid_l, 1'b0);
    #1; rst_n = 1'b1;
    send_word(24'h5A5A5A, 0, 0);
    idle(3);
    check("after_rst_word", last_l, 24'h5A5A5A);
    $display("reset mid-word: got=%h", last_l);

    // MSB-first stream; the MSB_FIRST instance must rebuild the word.
    send_word(24'h800001, 1, 0);
    idle(3);
    check("msb_word", last_m, 24'h800001);
    send_word(24'h0F00F1, 1, 0);
    idle(3);
    check("msb_word2", last_m, 24'h0F00F1);
    check("msb_on_lsb_inst", last_l, 24'h8F00F0);
    $display("msb: got=%h", last_m);

    // Random words with random consumer stalls and sender gaps.
    got_q.delete(); sent_q.delete();
    collect = 1; rand_ready = 1;
    for (int i = 0; i < 30; i++) begin
      w = L'($urandom);
      sent_q.push_back(w);
      for (int k = 0; k < L; k++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        send_bit(w[k]);
      end
    end
    rand_ready = 0;
    @(negedge clk); #1; i_ready = 1'b1;
    idle(10);
    collect = 0;
    check("rand_count", L'(got_q.size()), L'(sent_q.size()));
    for (int i = 0; i < sent_q.size() && i < got_q.size(); i++)
      check("rand_word", got_q[i], sent_q[i]);
    $display("random: sent=%0d got=%0d", sent_q.size(), got_q.size());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
